ber_test_sequencer: RTL and testbench

- Run controller for the RX bit-error test datapath.
- On an MCU start command it clears and arms the RX checker, then waits for pattern sync with a timeout.
- It then gates the checker for exactly TEST_LEN clocks, freezes it, and computes the pass percentage with a sequential divider.
- It reports the result as a framed byte stream over the UART ready/valid interface.
- It replaces the free-running counter and trigger logic in the checker; the checker becomes a pure datapath.

---
 rtl/ber_pkg.sv | 28 ++
 rtl/ber_seq_divider.sv | 63 ++++++
 rtl/ber_test_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_ber_test_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared definitions for the BER test sequencer: FSM states, report status codes,
// frame lengths and divider sizing.
package ber_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SYNC   = 3'd2,
        RUN    = 3'd3,
        LATCH  = 3'd4,
        DIVIDE = 3'd5,
        SEND   = 3'd6
    } ber_state_t;

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_TMO   = 8'h01;
    localparam logic [7:0] ST_ABORT = 8'h02;

    localparam int FRAME_LEN_BASIC = 4;
    localparam int FRAME_LEN_RAW   = 12;

    localparam int DIV_STEPS = 40;

    function automatic logic [7:0] clamp_percent(input logic [39:0] q);
        return (q > 40'd100) ? 8'd100 : q[7:0];
    endfunction

endpackage

// File: rtl/ber_seq_divider.sv
// 40/32 restoring divider: one quotient bit per clock, done pulses 40 clocks after start.
// Quotient and remainder are held until the next start.
module ber_seq_divider
    import ber_pkg::*;
(
    input  logic        clk9MHz,
    input  logic        rst_n,
    input  logic        start,
    input  logic [39:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [39:0] quotient,
    output logic [31:0] remainder
);

    logic [39:0] quo_reg;
    logic [31:0] rem_reg;
    logic [5:0]  cnt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [32:0] trial;
    logic [32:0] diff;

    // Shift the next dividend bit into the partial remainder; a borrow means "does not fit".
    assign trial = {rem_reg, quo_reg[39]};
    assign diff  = trial - {1'b0, divisor};

    always_ff @(posedge clk9MHz or negedge rst_n) begin
        if (!rst_n) begin
            quo_reg  <= '0;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                quo_reg  <= dividend;
                rem_reg  <= '0;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                if (!diff[32]) begin
                    rem_reg <= diff[31:0];
                    quo_reg <= {quo_reg[38:0], 1'b1};
                end else begin
                    rem_reg <= trial[31:0];
                    quo_reg <= {quo_reg[38:0], 1'b0};
                end
                cnt_reg <= cnt_reg + 6'd1;
                if (cnt_reg == 6'(DIV_STEPS - 1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done      = done_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/ber_test_sequencer.sv
// Run controller for the RX bit-error checker: clear, sync, timed run, percent, framed report.
// Define BER_RAW_COUNT_REPORT_EN to append raw pass/fail counts to the report frame.
module ber_test_sequencer
    import ber_pkg::*;
#(
    parameter logic [31:0] TEST_LEN     = 32'd80_000_000,
    parameter logic [31:0] SYNC_TIMEOUT = 32'd9_000_000,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic        clk9MHz,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        rx_started_flag,
    input  logic [31:0] pass_cnt,
    input  logic [31:0] fail_cnt,
    output logic        rx_clr,
    output logic        rx_enable,
    output logic        busy,
    output logic        to_uart_valid,
    output logic [7:0]  to_uart_data,
    input  logic        to_uart_ready
);

`ifdef BER_RAW_COUNT_REPORT_EN
    localparam int FRAME_LEN = FRAME_LEN_RAW;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASIC;
`endif

    ber_state_t  state_reg, state_next;
    logic [31:0] tmo_cnt_reg, tmo_cnt_next;
    logic [31:0] run_cnt_reg, run_cnt_next;
    logic        clr_cnt_reg, clr_cnt_next;
    logic        lat_cnt_reg, lat_cnt_next;
    logic [7:0]  status_reg, status_next;
    logic [7:0]  percent_reg, percent_next;
    logic [3:0]  byte_idx_reg, byte_idx_next;

    logic        div_start;
    logic        div_done;
    logic [39:0] dividend;
    logic [39:0] quotient;
    logic [31:0] unused_rem;

    logic [7:0]  body [FRAME_LEN-1];
    logic [7:0]  csum;

    // pass*100 built from shifts: 64 + 32 + 4.
    assign dividend = ({8'd0, pass_cnt} << 6) + ({8'd0, pass_cnt} << 5) + ({8'd0, pass_cnt} << 2);

    ber_seq_divider u_div (
        .clk9MHz   (clk9MHz),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (dividend),
        .divisor   (TEST_LEN),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (unused_rem)
    );

    always_ff @(posedge clk9MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tmo_cnt_reg  <= '0;
            run_cnt_reg  <= '0;
            clr_cnt_reg  <= 1'b0;
            lat_cnt_reg  <= 1'b0;
            status_reg   <= '0;
            percent_reg  <= '0;
            byte_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            run_cnt_reg  <= run_cnt_next;
            clr_cnt_reg  <= clr_cnt_next;
            lat_cnt_reg  <= lat_cnt_next;
            status_reg   <= status_next;
            percent_reg  <= percent_next;
            byte_idx_reg <= byte_idx_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        run_cnt_next  = run_cnt_reg;
        clr_cnt_next  = clr_cnt_reg;
        lat_cnt_next  = lat_cnt_reg;
        status_next   = status_reg;
        percent_next  = percent_reg;
        byte_idx_next = byte_idx_reg;
        div_start     = 1'b0;
        rx_clr        = 1'b0;
        rx_enable     = 1'b0;
        to_uart_valid = 1'b0;
        busy          = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = 1'b0;
                end
            end
            CLEAR: begin
                rx_clr = 1'b1;
                if (clr_cnt_reg) begin
                    state_next   = SYNC;
                    tmo_cnt_next = '0;
                end else begin
                    clr_cnt_next = 1'b1;
                end
            end
            SYNC: begin
                rx_enable    = 1'b1;
                tmo_cnt_next = tmo_cnt_reg + 32'd1;
                if (abort) begin
                    status_next   = ST_ABORT;
                    percent_next  = 8'h00;
                    byte_idx_next = '0;
                    state_next    = SEND;
                end else if (rx_started_flag) begin
                    run_cnt_next = '0;
                    state_next   = RUN;
                end else if (tmo_cnt_reg == SYNC_TIMEOUT - 32'd1) begin
                    status_next   = ST_TMO;
                    percent_next  = 8'h00;
                    byte_idx_next = '0;
                    state_next    = SEND;
                end
            end
            RUN: begin
                rx_enable    = 1'b1;
                run_cnt_next = run_cnt_reg + 32'd1;
                if (abort) begin
                    status_next   = ST_ABORT;
                    percent_next  = 8'h00;
                    byte_idx_next = '0;
                    state_next    = SEND;
                end else if (run_cnt_reg == TEST_LEN - 32'd1) begin
                    lat_cnt_next = 1'b0;
                    state_next   = LATCH;
                end
            end
            LATCH: begin
                // Second settle cycle: counts are final, sample them into the divider.
                if (lat_cnt_reg) begin
                    div_start  = 1'b1;
                    state_next = DIVIDE;
                end else begin
                    lat_cnt_next = 1'b1;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    status_next   = ST_OK;
                    percent_next  = clamp_percent(quotient);
                    byte_idx_next = '0;
                    state_next    = SEND;
                end
            end
            SEND: begin
                to_uart_valid = 1'b1;
                if (to_uart_ready) begin
                    if (byte_idx_reg == 4'(FRAME_LEN - 1)) begin
                        state_next = IDLE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign body[0] = HDR_BYTE;
    assign body[1] = status_reg;
    assign body[2] = percent_reg;

`ifdef BER_RAW_COUNT_REPORT_EN
    logic [31:0] pass_reg;
    logic [31:0] fail_reg;

    // Cleared at run start so timeout/abort frames report zero counts.
    always_ff @(posedge clk9MHz or negedge rst_n) begin
        if (!rst_n) begin
            pass_reg <= '0;
            fail_reg <= '0;
        end else if (state_reg == CLEAR) begin
            pass_reg <= '0;
            fail_reg <= '0;
        end else if (div_start) begin
            pass_reg <= pass_cnt;
            fail_reg <= fail_cnt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_raw
            assign body[3+gi] = pass_reg[31-8*gi -: 8];
            assign body[7+gi] = fail_reg[31-8*gi -: 8];
        end
    endgenerate
`else
    logic unused_fail;
    assign unused_fail = ^fail_cnt;
`endif

    always_comb begin
        csum = 8'h00;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            csum = csum ^ body[i];
        end
    end

    always_comb begin
        to_uart_data = 8'h00;
        if (state_reg == SEND) begin
            if (byte_idx_reg == 4'(FRAME_LEN - 1)) begin
                to_uart_data = csum;
            end
            for (int i = 0; i < FRAME_LEN - 1; i++) begin
                if (byte_idx_reg == 4'(i)) begin
                    to_uart_data = body[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Scoreboard bench for ber_test_sequencer with TEST_LEN=100, SYNC_TIMEOUT=50.
`timescale 1ns/1ps
module tb_ber_test_sequencer;

    localparam int TL = 100;
    localparam int ST = 50;
    localparam int K_NOM = 0;
    localparam int K_TMO = 1;
    localparam int K_ABT = 2;

    logic        clk9MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rx_started_flag = 1'b0;
    logic [31:0] pass_cnt = '0;
    logic [31:0] fail_cnt = '0;
    logic        rx_clr;
    logic        rx_enable;
    logic        busy;
    logic        to_uart_valid;
    logic [7:0]  to_uart_data;
    logic        to_uart_ready = 1'b1;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    bit          bp_mode = 1'b0;

    ber_test_sequencer #(
        .TEST_LEN     (32'd100),
        .SYNC_TIMEOUT (32'd50),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .clk9MHz         (clk9MHz),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .rx_started_flag (rx_started_flag),
        .pass_cnt        (pass_cnt),
        .fail_cnt        (fail_cnt),
        .rx_clr          (rx_clr),
        .rx_enable       (rx_enable),
        .busy            (busy),
        .to_uart_valid   (to_uart_valid),
        .to_uart_data    (to_uart_data),
        .to_uart_ready   (to_uart_ready)
    );

    always #55 clk9MHz = ~clk9MHz;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Reference frame built directly from the report format rules.
    task automatic push_frame(input logic [7:0] status, input logic [7:0] pct,
                              input logic [31:0] p, input logic [31:0] f);
        logic [7:0] fr[$];
        logic [7:0] cs;
        cs = 8'h00;
        fr.push_back(8'hA5);
        fr.push_back(status);
        fr.push_back(pct);
`ifdef BER_RAW_COUNT_REPORT_EN
        for (int i = 3; i >= 0; i--) fr.push_back(p[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fr.push_back(f[8*i +: 8]);
`else
        if (p == f) cs = 8'h00;
`endif
        foreach (fr[i]) cs = cs ^ fr[i];
        fr.push_back(cs);
        foreach (fr[i]) exp_q.push_back(fr[i]);
    endtask

    // Ready driver: with backpressure, hold ready low for 7 cycles of every presented byte.
    initial begin
        int hold_cnt;
        hold_cnt = 0;
        forever begin
            @(posedge clk9MHz);
            #1;
            if (!bp_mode) begin
                to_uart_ready = 1'b1;
                hold_cnt = 0;
            end else if (to_uart_valid) begin
                if (hold_cnt == 7) begin
                    to_uart_ready = 1'b1;
                    hold_cnt = 0;
                end else begin
                    to_uart_ready = 1'b0;
                    hold_cnt++;
                end
            end else begin
                to_uart_ready = 1'b0;
                hold_cnt = 0;
            end
        end
    end

    // Monitor: pops expected bytes on each handshake and checks byte stability while stalled.
    initial begin
        bit         hold_pending;
        logic [7:0] hold_data;
        logic [7:0] e;
        hold_pending = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge clk9MHz);
            if (!rst_n) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", to_uart_valid, 1);
                    check("hold_data", to_uart_data, hold_data);
                end
                if (to_uart_valid && to_uart_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h, required no byte", to_uart_data);
                    end else begin
                        e = exp_q.pop_front();
                        $display("uart byte %02h (expected %02h)", to_uart_data, e);
                        check("frame_byte", to_uart_data, e);
                    end
                end
                hold_pending = to_uart_valid && !to_uart_ready;
                hold_data = to_uart_data;
            end
        end
    end

    task automatic pulse_start_count_clr();
        int n;
        @(negedge clk9MHz); start = 1'b1;
        @(negedge clk9MHz); start = 1'b0;
        n = 0;
        while (rx_clr && n < 10) begin
            n++;
            @(negedge clk9MHz);
        end
        check("rx_clr_cycles", n, 2);
    endtask

    task automatic do_run(input int kind, input logic [31:0] p, input logic [31:0] f,
                          input int sync_delay, input int abort_at, input bit mid_start, input bit bp);
        int     n;
        longint pc;
        pass_cnt = p;
        fail_cnt = f;
        rx_started_flag = 1'b0;
        bp_mode = bp;
        pc = (longint'(p) * 100) / TL;
        if (pc > 100) pc = 100;
        if (kind == K_NOM) push_frame(8'h00, 8'(pc), p, f);
        else if (kind == K_TMO) push_frame(8'h01, 8'h00, 32'd0, 32'd0);
        else push_frame(8'h02, 8'h00, 32'd0, 32'd0);
        $display("run kind=%0d pass=%0d fail=%0d sync_delay=%0d abort_at=%0d bp=%0b",
                 kind, p, f, sync_delay, abort_at, bp);

        pulse_start_count_clr();
        if (kind == K_TMO) begin
            n = 0;
            while (rx_enable && n < 200) begin
                n++;
                @(negedge clk9MHz);
            end
            check("sync_timeout_cycles", n, ST);
        end else begin
            repeat (sync_delay) @(negedge clk9MHz);
            rx_started_flag = 1'b1;
            n = 0;
            while (n < 300) begin
                @(negedge clk9MHz);
                if (!rx_enable) break;
                n++;
                start = (mid_start && n == 40);
                abort = (kind == K_ABT && n == abort_at);
            end
            start = 1'b0;
            abort = 1'b0;
            check("run_enable_cycles", n, (kind == K_ABT) ? abort_at : TL);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk9MHz);
            n++;
        end
        check("frame_drained", exp_q.size(), 0);
        @(negedge clk9MHz);
        check("busy_after_frame", busy, 0);
        bp_mode = 1'b0;
    endtask

    initial begin
        int n;
        #5;
        check("reset_outputs", {busy, rx_clr, rx_enable, to_uart_valid, to_uart_data}, 0);
        repeat (3) @(negedge clk9MHz);
        rst_n = 1'b1;

        do_run(K_NOM, 32'd97, 32'd3, 5, 0, 1'b0, 1'b0);
        do_run(K_TMO, 32'd97, 32'd3, 0, 0, 1'b0, 1'b0);
        do_run(K_ABT, 32'd97, 32'd3, 5, 30, 1'b0, 1'b0);
        do_run(K_NOM, 32'd120, 32'd0, 5, 0, 1'b0, 1'b1);

        // Reset in the middle of DIVIDE, then restart straight away with a start pulse mid-RUN.
        pass_cnt = 32'd97;
        rx_started_flag = 1'b0;
        pulse_start_count_clr();
        repeat (3) @(negedge clk9MHz);
        rx_started_flag = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge clk9MHz);
            if (!rx_enable) break;
            n++;
        end
        repeat (10) @(negedge clk9MHz);
        check("busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, rx_clr, rx_enable, to_uart_valid, to_uart_data}, 0);
        @(negedge clk9MHz);
        rst_n = 1'b1;
        do_run(K_NOM, 32'd97, 32'd3, 2, 0, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            logic [31:0] p;
            int kind;
            p = (r == 5) ? $urandom : 32'($urandom_range(0, 140));
            kind = ($urandom_range(0, 3) == 0) ? K_ABT : K_NOM;
            do_run(kind, p, $urandom, $urandom_range(0, 40),
                   (kind == K_ABT) ? $urandom_range(1, 99) : 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
